hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/video_timing_pkg.sv | 23 ++
 rtl/hvsync_generator_if.sv | 14 +
 rtl/mod_counter.sv | 21 ++
 rtl/hvsync_generator.sv | 66 ++++++
 tb/tb_hvsync_generator.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - default video timing values and helpers shared by the sync generator and renderers
package video_timing_pkg;

    // Default 256x240 timing. The borders and sync widths add up to 309 clocks per line and 262 lines per frame.
    localparam int DEF_H_DISPLAY = 256;
    localparam int DEF_H_BACK    = 23;
    localparam int DEF_H_FRONT   = 7;
    localparam int DEF_H_SYNC    = 23;
    localparam int DEF_V_DISPLAY = 240;
    localparam int DEF_V_TOP     = 5;
    localparam int DEF_V_BOTTOM  = 14;
    localparam int DEF_V_SYNC    = 3;

    localparam int POS_W = 9;

    typedef logic [POS_W-1:0] pos_t;

    // Returns 1 when pos lies in the closed range [lo, hi].
    function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/hvsync_generator_if.sv
// rtl/hvsync_generator_if.sv - bundle of the generator's sync and position outputs
// source: driven by the generator; sink: read by a renderer or a checker.
interface hvsync_generator_if;
    import video_timing_pkg::*;

    logic hsync;
    logic vsync;
    logic display_on;
    pos_t hpos;
    pos_t vpos;

    modport source (output hsync, output vsync, output display_on, output hpos, output vpos);
    modport sink   (input  hsync, input  vsync, input  display_on, input  hpos, input  vpos);
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled counter that wraps from MAX back to 0
// Ports: clk, rst_n (async, active-low), en (count when high), count (current value).
module mod_counter #(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= (count == MAX) ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hvsync_generator.sv
// rtl/hvsync_generator.sv - horizontal/vertical sync and beam position generator
// Ports: clk (pixel clock), reset (async, active-low), hsync/vsync (registered, active-high),
// display_on (combinational visible-area flag), hpos/vpos (9-bit beam column/line).
module hvsync_generator
    import video_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_TOP     = DEF_V_TOP,
    parameter int V_BOTTOM  = DEF_V_BOTTOM,
    parameter int V_SYNC    = DEF_V_SYNC
) (
    input  logic clk,
    input  logic reset,
    output logic hsync,
    output logic vsync,
    output logic display_on,
    output pos_t hpos,
    output pos_t vpos
);

    localparam pos_t H_VIS        = pos_t'(H_DISPLAY);
    localparam pos_t H_SYNC_START = pos_t'(H_DISPLAY + H_FRONT);
    localparam pos_t H_SYNC_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam pos_t H_MAX        = pos_t'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
    localparam pos_t V_VIS        = pos_t'(V_DISPLAY);
    localparam pos_t V_SYNC_START = pos_t'(V_DISPLAY + V_BOTTOM);
    localparam pos_t V_SYNC_END   = pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam pos_t V_MAX        = pos_t'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);

    logic h_wrap;

    // The line counter advances only on the edge where the pixel counter wraps.
    assign h_wrap = (hpos == H_MAX);

    mod_counter #(.WIDTH(POS_W), .MAX(H_MAX)) u_h_counter (
        .clk   (clk),
        .rst_n (reset),
        .en    (1'b1),
        .count (hpos)
    );

    mod_counter #(.WIDTH(POS_W), .MAX(V_MAX)) u_v_counter (
        .clk   (clk),
        .rst_n (reset),
        .en    (h_wrap),
        .count (vpos)
    );

    // Syncs sample the pre-edge position, so each pulse trails its window by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            hsync <= in_window(hpos, H_SYNC_START, H_SYNC_END);
            vsync <= in_window(vpos, V_SYNC_START, V_SYNC_END);
        end
    end

    assign display_on = (hpos < H_VIS) && (vpos < V_VIS);

endmodule

// File: tb/tb_hvsync_generator.sv
// tb/tb_hvsync_generator.sv - self-checking bench for hvsync_generator
module tb_hvsync_generator;

    localparam int HT = 309;
    localparam int VT = 262;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    // Clocks elapsed since each instance last left reset.
    int t_a = 0;
    int t_b = 0;

    // Frame statistics for instance A.
    logic prev_hs;
    logic prev_de;
    int   hs_rises, hs_line0_high, vs_high, bottom_low, bottom_high, max_h_line0;
    int   first_rise_h, first_fall_h, de_drop_h, first_vs_h, first_vs_v;

    hvsync_generator_if va ();
    hvsync_generator_if vb ();

    hvsync_generator dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .hsync      (va.hsync),
        .vsync      (va.vsync),
        .display_on (va.display_on),
        .hpos       (va.hpos),
        .vpos       (va.vpos)
    );

    hvsync_generator dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .hsync      (vb.hsync),
        .vsync      (vb.vsync),
        .display_on (vb.display_on),
        .hpos       (vb.hpos),
        .vpos       (vb.vpos)
    );

    always #5 clk = ~clk;

    // Reference model: position and syncs as plain functions of clocks since reset.
    function automatic int m_h(input int t);
        return t % HT;
    endfunction

    function automatic int m_v(input int t);
        return (t / HT) % VT;
    endfunction

    function automatic int m_hs(input int t);
        int h;
        if (t == 0) return 0;
        h = (t - 1) % HT;
        return (h >= 263 && h <= 285) ? 1 : 0;
    endfunction

    function automatic int m_vs(input int t);
        int v;
        if (t == 0) return 0;
        v = ((t - 1) / HT) % VT;
        return (v >= 254 && v <= 256) ? 1 : 0;
    endfunction

    function automatic int m_de(input int t);
        return (m_h(t) < 256 && m_v(t) < 240) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut();
        chk("a_hpos",       32'(va.hpos),       m_h(t_a));
        chk("a_vpos",       32'(va.vpos),       m_v(t_a));
        chk("a_hsync",      32'(va.hsync),      m_hs(t_a));
        chk("a_vsync",      32'(va.vsync),      m_vs(t_a));
        chk("a_display_on", 32'(va.display_on), m_de(t_a));
        chk("b_hpos",       32'(vb.hpos),       m_h(t_b));
        chk("b_vpos",       32'(vb.vpos),       m_v(t_b));
        chk("b_hsync",      32'(vb.hsync),      m_hs(t_b));
        chk("b_vsync",      32'(vb.vsync),      m_vs(t_b));
        chk("b_display_on", 32'(vb.display_on), m_de(t_b));
    endtask

    task automatic clear_stats();
        prev_hs = 1'b0;
        prev_de = 1'b1;
        hs_rises = 0; hs_line0_high = 0; vs_high = 0; bottom_low = 0; bottom_high = 0; max_h_line0 = 0;
        first_rise_h = -1; first_fall_h = -1; de_drop_h = -1; first_vs_h = -1; first_vs_v = -1;
    endtask

    task automatic update_stats();
        if (va.hsync && !prev_hs) begin
            hs_rises++;
            if (first_rise_h < 0) first_rise_h = int'(va.hpos);
        end
        if (!va.hsync && prev_hs && first_fall_h < 0) first_fall_h = int'(va.hpos);
        if (va.hsync && va.vpos == 9'd0 && t_a <= HT) hs_line0_high++;
        if (t_a <= HT && int'(va.hpos) > max_h_line0) max_h_line0 = int'(va.hpos);
        if (!va.display_on && prev_de && de_drop_h < 0) de_drop_h = int'(va.hpos);
        if (va.vsync) begin
            vs_high++;
            if (first_vs_h < 0) begin
                first_vs_h = int'(va.hpos);
                first_vs_v = int'(va.vpos);
            end
        end
        if (va.vpos >= 9'd240) begin
            if (va.display_on) bottom_high++;
            else bottom_low++;
        end
        prev_hs = va.hsync;
        prev_de = va.display_on;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        t_a = rst_a ? t_a + 1 : 0;
        t_b = rst_b ? t_b + 1 : 0;
        @(negedge clk);
        check_dut();
        update_stats();
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        clear_stats();

        // Reset held with the clock running.
        repeat (3) step();
        chk("rst_hpos", 32'(va.hpos), 0);
        chk("rst_vpos", 32'(va.vpos), 0);
        chk("rst_hsync", 32'(va.hsync), 0);
        chk("rst_vsync", 32'(va.vsync), 0);
        chk("rst_display_on", 32'(va.display_on), 1);

        // Release both instances and start frame statistics.
        rst_a = 1'b1;
        rst_b = 1'b1;
        clear_stats();
        step();
        chk("first_edge_hpos", 32'(va.hpos), 1);

        // First line complete.
        repeat (HT - 1) step();
        chk("line_wrap_hpos", 32'(va.hpos), 0);
        chk("line_wrap_vpos", 32'(va.vpos), 1);
        chk("line0_max_hpos", 32'(max_h_line0), 308);
        chk("hsync_rise_hpos", 32'(first_rise_h), 264);
        chk("hsync_fall_hpos", 32'(first_fall_h), 287);
        chk("hsync_line0_width", 32'(hs_line0_high), 23);
        chk("display_drop_hpos", 32'(de_drop_h), 256);

        // Walk to line 255, column 270, where both syncs are high, then reset instance B there.
        repeat (255 * HT + 270 - t_a) step();
        chk("b_pre_reset_hpos", 32'(vb.hpos), 270);
        chk("b_pre_reset_vpos", 32'(vb.vpos), 255);
        chk("b_pre_reset_hsync", 32'(vb.hsync), 1);
        chk("b_pre_reset_vsync", 32'(vb.vsync), 1);
        rst_b = 1'b0;
        t_b = 0;
        #1;
        chk("b_async_hpos", 32'(vb.hpos), 0);
        chk("b_async_vpos", 32'(vb.vpos), 0);
        chk("b_async_hsync", 32'(vb.hsync), 0);
        chk("b_async_vsync", 32'(vb.vsync), 0);
        chk("b_async_display_on", 32'(vb.display_on), 1);
        repeat (2) step();
        rst_b = 1'b1;

        // Finish the frame on instance A.
        repeat (FRAME - t_a) step();
        chk("frame_end_hpos", 32'(va.hpos), 0);
        chk("frame_end_vpos", 32'(va.vpos), 0);
        chk("frame_end_display_on", 32'(va.display_on), 1);
        chk("frame_hsync_rises", 32'(hs_rises), 262);
        chk("frame_vsync_high", 32'(vs_high), 3 * HT);
        chk("vsync_start_vpos", 32'(first_vs_v), 254);
        chk("vsync_start_hpos", 32'(first_vs_h), 1);
        chk("bottom_display_low", 32'(bottom_low), 22 * HT);
        chk("bottom_display_high", 32'(bottom_high), 0);

        // Random run lengths with random asynchronous resets on either instance.
        for (int i = 0; i < 10; i++) begin
            int n;
            int hold;
            n = $urandom_range(20, 300);
            hold = $urandom_range(0, 2);
            repeat (n) step();
            if ($urandom_range(0, 1) == 0) begin
                rst_a = 1'b0;
                t_a = 0;
            end else begin
                rst_b = 1'b0;
                t_b = 0;
            end
            #1;
            check_dut();
            repeat (hold) step();
            rst_a = 1'b1;
            rst_b = 1'b1;
        end
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
